seg7_scan_decoder: RTL and testbench

Receive-side counterpart of the team's hex-to-7-segment encoder. Monitors a time-multiplexed 7-segment display bus (segment lines plus per-digit anode enables), waits for each digit's drive to settle, decodes the segment pattern back to a 4-bit hex value, and assembles a full multi-digit word with per-digit validity. Used as an in-fabric display monitor and as a self-check on the display driver path.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_pattern_decode.sv | 36 +++
 rtl/seg7_scan_decoder.sv | 130 +++++++++++++
 tb/tb_seg7_scan_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: normalized (1 = lit) glyph patterns and segment bit positions.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned HEX_W = 4;

    localparam int unsigned SEG_A = 6;
    localparam int unsigned SEG_B = 5;
    localparam int unsigned SEG_C = 4;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 2;
    localparam int unsigned SEG_F = 1;
    localparam int unsigned SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h7E;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h30;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h33;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h5F;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h70;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h7B;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h1F;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h0D;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h3D;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h47;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a normalized segment pattern to its hex value.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [HEX_W-1:0] hex,
    output logic             hit,
    output logic             blank
);

    always_comb begin
        hex   = '0;
        hit   = 1'b1;
        blank = (pattern == SEG_BLANK);
        case (pattern)
            GLYPH_0: hex = 4'h0;
            GLYPH_1: hex = 4'h1;
            GLYPH_2: hex = 4'h2;
            GLYPH_3: hex = 4'h3;
            GLYPH_4: hex = 4'h4;
            GLYPH_5: hex = 4'h5;
            GLYPH_6: hex = 4'h6;
            GLYPH_7: hex = 4'h7;
            GLYPH_8: hex = 4'h8;
            GLYPH_9: hex = 4'h9;
            GLYPH_A: hex = 4'hA;
            GLYPH_B: hex = 4'hB;
            GLYPH_C: hex = 4'hC;
            GLYPH_D: hex = 4'hD;
            GLYPH_E: hex = 4'hE;
            GLYPH_F: hex = 4'hF;
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus, captures each digit once its drive has settled,
// and assembles the decoded digits into a word with per-digit validity and frame pulses.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SEG_W-1:0]            seg_in,
    input  logic [NUM_DIGITS-1:0]       an_in,
    output logic [HEX_W*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]       digit_valid,
    output logic                        frame_strobe,
    output logic                        frame_valid,
    output logic                        decode_err
);

    localparam int unsigned     CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]      seg_norm_c;
    logic [NUM_DIGITS-1:0] an_norm_c;
    logic [SEG_W-1:0]      r_seg, h_seg;
    logic [NUM_DIGITS-1:0] r_an, h_an;
    logic [CNT_W-1:0]      cnt;
    logic                  captured;
    logic [NUM_DIGITS-1:0] seen;

    logic                        stable_c, onehot_c, capture_c;
    logic [HEX_W-1:0]            dec_hex_c;
    logic                        dec_hit_c, dec_blank_c;
    logic [HEX_W*NUM_DIGITS-1:0] hex_nxt;
    logic [NUM_DIGITS-1:0]       valid_nxt, seen_nxt, seen_upd;
    logic                        strobe_nxt, fvalid_nxt, err_nxt;

    assign seg_norm_c = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    assign an_norm_c  = AN_ACTIVE_LOW  ? ~an_in  : an_in;

    seg7_pattern_decode u_decode (
        .pattern (h_seg),
        .hex     (dec_hex_c),
        .hit     (dec_hit_c),
        .blank   (dec_blank_c)
    );

    // Capture decision and the resulting output/frame updates
    always_comb begin
        hex_nxt    = hex_out;
        valid_nxt  = digit_valid;
        seen_nxt   = seen;
        strobe_nxt = 1'b0;
        fvalid_nxt = frame_valid;
        err_nxt    = 1'b0;
        seen_upd   = seen | h_an;

        stable_c  = (r_seg == h_seg) && (r_an == h_an);
        onehot_c  = (h_an != '0) && ((h_an & (h_an - NUM_DIGITS'(1))) == '0);
        capture_c = stable_c && (cnt == CNT_MAX) && !captured && onehot_c;

        if (capture_c) begin
            if (dec_hit_c) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (h_an[i]) begin
                        hex_nxt[HEX_W*i +: HEX_W] = dec_hex_c;
                    end
                end
                valid_nxt = digit_valid | h_an;
            end else begin
                valid_nxt = digit_valid & ~h_an;
                err_nxt   = !dec_blank_c;
            end
            // Frame closes on the capture that fills in the last unseen digit
            if (seen_upd == '1) begin
                strobe_nxt = 1'b1;
                fvalid_nxt = &valid_nxt;
                seen_nxt   = '0;
            end else begin
                seen_nxt = seen_upd;
            end
        end
    end

    // Input sampling, candidate hold and stability counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg    <= '0;
            r_an     <= '0;
            h_seg    <= '0;
            h_an     <= '0;
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            r_seg <= seg_norm_c;
            r_an  <= an_norm_c;
            if (!stable_c) begin
                h_seg    <= r_seg;
                h_an     <= r_an;
                cnt      <= '0;
                captured <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else if (capture_c) begin
                captured <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out      <= '0;
            digit_valid  <= '0;
            seen         <= '0;
            frame_strobe <= 1'b0;
            frame_valid  <= 1'b0;
            decode_err   <= 1'b0;
        end else begin
            hex_out      <= hex_nxt;
            digit_valid  <= valid_nxt;
            seen         <= seen_nxt;
            frame_strobe <= strobe_nxt;
            frame_valid  <= fvalid_nxt;
            decode_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: run-length reference model plus directed checks.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [6:0]      seg_in = 7'h7F;
    logic [ND-1:0]   an_in = '1;
    logic [4*ND-1:0] hex_out;
    logic [ND-1:0]   digit_valid;
    logic            frame_strobe, frame_valid, decode_err;

    seg7_scan_decoder #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (SC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .an_in        (an_in),
        .hex_out      (hex_out),
        .digit_valid  (digit_valid),
        .frame_strobe (frame_strobe),
        .frame_valid  (frame_valid),
        .decode_err   (decode_err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

    int tests = 0;
    int fails = 0;
    int n_strobe = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // -1 = blank, -2 = not a glyph, otherwise the hex value
    function automatic int lookup(logic [6:0] p);
        if (p == 7'h00) return -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
        return -2;
    endfunction

    // Model: a digit is taken when the same (an, seg) has been sampled on SC+1 consecutive edges
    logic [ND+6:0]   m_last, m_cur;
    int              m_run, m_d, m_v;
    logic [4*ND-1:0] m_hex;
    logic [ND-1:0]   m_valid, m_seen;
    logic            m_strobe, m_fvalid, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_last = '0; m_run = 0; m_hex = '0; m_valid = '0; m_seen = '0;
            m_strobe = 1'b0; m_fvalid = 1'b0; m_err = 1'b0;
        end else begin
            m_strobe = 1'b0;
            m_err = 1'b0;
            if (m_run == SC + 1 && $countones(m_last[ND+6:7]) == 1) begin
                m_d = 0;
                for (int i = 0; i < ND; i++) if (m_last[7+i]) m_d = i;
                m_v = lookup(m_last[6:0]);
                if (m_v >= 0) begin
                    m_hex[4*m_d +: 4] = 4'(m_v);
                    m_valid[m_d] = 1'b1;
                end else begin
                    m_valid[m_d] = 1'b0;
                    m_err = (m_v == -2);
                end
                m_seen[m_d] = 1'b1;
                if (m_seen == '1) begin
                    m_strobe = 1'b1;
                    m_fvalid = &m_valid;
                    m_seen = '0;
                end
            end
            m_cur = {~an_in, ~seg_in};
            if (m_cur == m_last) begin
                if (m_run < 1000) m_run = m_run + 1;
            end else begin
                m_last = m_cur;
                m_run = 1;
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                tests++;
                if ({hex_out, digit_valid, frame_strobe, frame_valid, decode_err} !==
                    {m_hex, m_valid, m_strobe, m_fvalid, m_err}) begin
                    fails++;
                    $display("FAIL model_cmp @%0t: got hex=%h dv=%b fs=%b fv=%b err=%b, expected hex=%h dv=%b fs=%b fv=%b err=%b",
                             $time, hex_out, digit_valid, frame_strobe, frame_valid, decode_err,
                             m_hex, m_valid, m_strobe, m_fvalid, m_err);
                end
            end
            if (frame_strobe) n_strobe++;
            if (decode_err) n_err++;
        end
    endtask

    // Raw (active-low) bus values held for exactly n sampling edges
    task automatic hold(logic [ND-1:0] an, logic [6:0] seg, int n);
        @(negedge clk);
        an_in = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        // Reset
        #1 rst = 1'b1;
        #2 check("reset_outputs", 32'({hex_out, digit_valid, frame_strobe, frame_valid, decode_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        n_strobe = 0;
        hold(4'b1111, 7'b1111111, 20);
        settle();
        check("t1_no_strobe", 32'(n_strobe), 32'd0);

        // Single digit: capture visible after the 10th edge, not the 9th
        @(negedge clk);
        an_in = 4'b1110;
        seg_in = 7'b0000001;
        repeat (9) @(posedge clk);
        #1 check("t2_dv_edge9", 32'(digit_valid), 32'h0);
        @(posedge clk);
        #1 check("t2_dv_edge10", 32'(digit_valid), 32'h1);
        check("t2_hex0", 32'(hex_out[3:0]), 32'h0);
        check("t2_no_strobe", 32'(n_strobe), 32'd0);

        // Full frame 1,2,3,4
        n_strobe = 0;
        hold(4'b1110, 7'b1001111, 12);
        hold(4'b1101, 7'b0010010, 12);
        hold(4'b1011, 7'b0000110, 12);
        hold(4'b0111, 7'b1001100, 12);
        settle();
        check("t3_strobes", 32'(n_strobe), 32'd1);
        check("t3_hex", 32'(hex_out), 32'h4321);
        check("t3_fv", 32'(frame_valid), 32'h1);
        check("t3_dv", 32'(digit_valid), 32'hF);

        // Glitch shorter than the settle time
        hold(4'b1011, 7'b0000000, 5);
        hold(4'b1111, 7'b1111111, 12);
        settle();
        check("t4_dv", 32'(digit_valid), 32'hF);
        check("t4_hex", 32'(hex_out), 32'h4321);

        // Illegal "-" on digit 1, then complete the frame with 5,6,7
        n_err = 0;
        hold(4'b1101, 7'b1111110, 12);
        settle();
        check("t5_err_count", 32'(n_err), 32'd1);
        check("t5_dv", 32'(digit_valid), 32'hD);
        n_strobe = 0;
        hold(4'b1110, 7'b0100100, 12);
        hold(4'b1011, 7'b0100000, 12);
        hold(4'b0111, 7'b0001111, 12);
        settle();
        check("t5_strobes", 32'(n_strobe), 32'd1);
        check("t5_fv", 32'(frame_valid), 32'h0);
        check("t5_hex", 32'(hex_out), 32'h7625);

        // Several anodes at once, then a reset mid-frame
        n_err = 0;
        n_strobe = 0;
        hold(4'b1100, 7'b0000001, 20);
        settle();
        check("t6_multi_err", 32'(n_err), 32'd0);
        check("t6_multi_strobe", 32'(n_strobe), 32'd0);
        check("t6_multi_dv", 32'(digit_valid), 32'hD);
        hold(4'b1110, 7'b0000100, 12);
        hold(4'b1101, 7'b0001000, 12);
        settle();
        check("t6_pre_reset_hex", 32'(hex_out), 32'h76A9);
        @(posedge clk);
        #3 rst = 1'b1;
        an_in = '1;
        #1 check("t6_reset_outputs", 32'({hex_out, digit_valid, frame_strobe, frame_valid, decode_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n_strobe = 0;
        hold(4'b1110, 7'b1001111, 12);
        hold(4'b1101, 7'b0010010, 12);
        hold(4'b1011, 7'b0000110, 12);
        hold(4'b0111, 7'b1001100, 12);
        settle();
        check("t6_strobes", 32'(n_strobe), 32'd1);
        check("t6_fv", 32'(frame_valid), 32'h1);

        // Random scan traffic against the model
        for (int k = 0; k < 300; k++) begin
            int unsigned sel;
            int unsigned ssel;
            logic [ND-1:0] an;
            logic [6:0] seg;
            sel = $urandom_range(0, 9);
            if (sel < 7) an = ~(ND'(1) << $urandom_range(0, ND - 1));
            else if (sel == 7) an = '1;
            else an = ND'($urandom);
            ssel = $urandom_range(0, 9);
            if (ssel < 6) seg = ~glyph[$urandom_range(0, 15)];
            else if (ssel == 6) seg = 7'h7F;
            else seg = 7'($urandom);
            hold(an, seg, int'($urandom_range(1, 14)));
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
